core_rsp_arbiter: RTL and testbench

Shares the single UART response interface among up to eight hashing cores and the command decoder. Latches per-core reward/overflow events and command ack/err pulses, and selects one event at a time: err, then ack, then cores in round-robin order. For a core event it captures that core's nonce/time/version payload and freezes the core until its response has gone out. Sits between the core array and the response interface, driving that interface's interrupt inputs and `valid`, and consuming its `hold_val` and idle status.

---
 rtl/core_rsp_arbiter_if.sv | 28 ++
 rtl/core_rsp_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_core_rsp_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_rsp_arbiter_if.sv
// Response-side bus shared between core_rsp_arbiter (master) and the UART
// response interface (slave): interrupt pulses, granted core, payload, and
// the handshake/status signals coming back from the response side.
interface core_rsp_arbiter_if;
   logic        rsp_idle;
   logic        rsp_hold_val;
   logic        rsp_reward_found;
   logic        rsp_nonce_overflow;
   logic        rsp_ack;
   logic        rsp_err;
   logic [2:0]  rsp_core_addr;
   logic [31:0] rsp_nonce;
   logic [31:0] rsp_time;
   logic [31:0] rsp_version;
   logic        rsp_valid;

   modport master (
      input  rsp_idle, rsp_hold_val,
      output rsp_reward_found, rsp_nonce_overflow, rsp_ack, rsp_err,
      output rsp_core_addr, rsp_nonce, rsp_time, rsp_version, rsp_valid
   );

   modport slave (
      output rsp_idle, rsp_hold_val,
      input  rsp_reward_found, rsp_nonce_overflow, rsp_ack, rsp_err,
      input  rsp_core_addr, rsp_nonce, rsp_time, rsp_version, rsp_valid
   );
endinterface

// File: rtl/core_rsp_arbiter.sv
// core_rsp_arbiter: latches per-core reward/overflow and command ack/err
// events and serves them one at a time on the shared response interface
// (err > ack > cores in round-robin order, reward before overflow per core).
// Optional watchdog on PRESENT/DRAIN: define RSP_ARB_TIMEOUT_EN.
module core_rsp_arbiter #(
   parameter int N_CORES        = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  sys_clk,
   input  logic                  rstn,
   input  logic [N_CORES-1:0]    core_reward,
   input  logic [N_CORES-1:0]    core_ovf,
   input  logic [32*N_CORES-1:0] core_nonce,
   input  logic [32*N_CORES-1:0] core_time,
   input  logic [32*N_CORES-1:0] core_version,
   output logic [N_CORES-1:0]    core_hold,
   input  logic                  cmd_ack,
   input  logic                  cmd_err,
   core_rsp_arbiter_if.master    rsp,
   output logic                  lost_evt
);
   typedef enum logic [1:0] {IDLE, ISSUE, PRESENT, DRAIN} state_t;
   typedef enum logic [1:0] {K_ERR, K_ACK, K_RWD, K_OVF} kind_t;

   state_t             state_reg, state_next;
   kind_t              kind_reg, pick_kind;
   logic [2:0]         core_reg, pick_core, rr_ptr;
   logic [N_CORES-1:0] p_rwd, p_ovf, rwd_next, ovf_next, clr_rwd, clr_ovf;
   logic               p_ack, p_err, ack_next, err_next;
   logic [7:0]         pend8, rwd8;
   logic [3:0]         idx;
   logic               any_core, any_pend, pick_is_core;
   logic               seen_reg, wait_reg;
   logic               capture, done, abandon, to_hit, lost_next;

   // Flag clears for the event currently being completed (or abandoned)
   genvar gi;
   generate
      for (gi = 0; gi < N_CORES; gi++) begin : g_core
         assign clr_rwd[gi] = done && (kind_reg == K_RWD) && (core_reg == 3'(gi));
         assign clr_ovf[gi] = done && (kind_reg == K_OVF) && (core_reg == 3'(gi));
      end
   endgenerate

   assign rwd_next = (p_rwd | core_reward) & ~clr_rwd;
   assign ovf_next = (p_ovf | core_ovf) & ~clr_ovf;
   assign ack_next = (p_ack | cmd_ack) & ~(done && (kind_reg == K_ACK));
   assign err_next = (p_err | cmd_err) & ~(done && (kind_reg == K_ERR));

   // A pulse landing on an already-set flag is dropped; so is an abandoned event
   assign lost_next = (|(core_reward & p_rwd)) | (|(core_ovf & p_ovf))
                    | (cmd_ack & p_ack) | (cmd_err & p_err) | abandon;

   assign pend8 = 8'(p_rwd | p_ovf);
   assign rwd8  = 8'(p_rwd);

   // Round-robin search for the first core with anything pending, from rr_ptr up
   always_comb begin
      pick_core = 3'd0;
      any_core  = 1'b0;
      idx       = 4'd0;
      for (int k = 0; k < N_CORES; k++) begin
         idx = {1'b0, rr_ptr} + 4'(k);
         if (idx >= 4'(N_CORES)) idx = idx - 4'(N_CORES);
         if (!any_core && pend8[idx[2:0]]) begin
            any_core  = 1'b1;
            pick_core = idx[2:0];
         end
      end
   end

   // Event class selection: err beats ack beats cores; reward beats overflow
   always_comb begin
      if (p_err)                pick_kind = K_ERR;
      else if (p_ack)           pick_kind = K_ACK;
      else if (rwd8[pick_core]) pick_kind = K_RWD;
      else                      pick_kind = K_OVF;
   end

   assign pick_is_core = (pick_kind == K_RWD) || (pick_kind == K_OVF);
   assign any_pend     = p_err | p_ack | any_core;

`ifdef RSP_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_reg;

   assign to_hit = ((state_reg == PRESENT) || (state_reg == DRAIN))
                && (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts cycles spent in PRESENT/DRAIN, restarts on any state change
   always_ff @(posedge sys_clk) begin
      if (!rstn || (state_next != state_reg))
         to_cnt_reg <= '0;
      else if ((state_reg == PRESENT) || (state_reg == DRAIN))
         to_cnt_reg <= to_cnt_reg + 1'b1;
   end
`else
   // No watchdog in this build: never fires, the FSM waits indefinitely
   assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Next-state logic; watchdog abandon overrides normal progress
   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      done       = 1'b0;
      abandon    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rsp.rsp_idle && any_pend) begin
               capture    = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = PRESENT;
         PRESENT: begin
            if (!rsp.rsp_hold_val && (seen_reg || wait_reg)) state_next = DRAIN;
         end
         DRAIN: begin
            if (rsp.rsp_idle) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (to_hit) begin
         done       = 1'b1;
         abandon    = 1'b1;
         state_next = IDLE;
      end
   end

   // Pending flags, core freeze and sticky lost indicator
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         p_rwd     <= '0;
         p_ovf     <= '0;
         p_ack     <= 1'b0;
         p_err     <= 1'b0;
         core_hold <= '0;
         lost_evt  <= 1'b0;
      end else begin
         p_rwd     <= rwd_next;
         p_ovf     <= ovf_next;
         p_ack     <= ack_next;
         p_err     <= err_next;
         core_hold <= rwd_next | ovf_next;
         lost_evt  <= lost_evt | lost_next;
      end
   end

   // FSM state, grant bookkeeping and hold_val tracking in PRESENT
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state_reg <= IDLE;
         kind_reg  <= K_ERR;
         core_reg  <= 3'd0;
         rr_ptr    <= 3'd0;
         seen_reg  <= 1'b0;
         wait_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            kind_reg <= pick_kind;
            core_reg <= pick_is_core ? pick_core : 3'd0;
         end
         if (done && ((kind_reg == K_RWD) || (kind_reg == K_OVF)))
            rr_ptr <= (core_reg == 3'(N_CORES - 1)) ? 3'd0 : core_reg + 3'd1;
         // wait_reg marks one low sample without hold_val; a second one gives up
         if (state_reg == PRESENT) begin
            if (rsp.rsp_hold_val) seen_reg <= 1'b1;
            else if (!seen_reg)   wait_reg <= 1'b1;
         end else begin
            seen_reg <= 1'b0;
            wait_reg <= 1'b0;
         end
      end
   end

   // Registered response outputs: interrupt pulse, captured payload, valid
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         rsp.rsp_reward_found   <= 1'b0;
         rsp.rsp_nonce_overflow <= 1'b0;
         rsp.rsp_ack            <= 1'b0;
         rsp.rsp_err            <= 1'b0;
         rsp.rsp_core_addr      <= 3'd0;
         rsp.rsp_nonce          <= 32'd0;
         rsp.rsp_time           <= 32'd0;
         rsp.rsp_version        <= 32'd0;
         rsp.rsp_valid          <= 1'b0;
      end else begin
         rsp.rsp_reward_found   <= capture && (pick_kind == K_RWD);
         rsp.rsp_nonce_overflow <= capture && (pick_kind == K_OVF);
         rsp.rsp_ack            <= capture && (pick_kind == K_ACK);
         rsp.rsp_err            <= capture && (pick_kind == K_ERR);
         if (capture) begin
            rsp.rsp_core_addr <= pick_is_core ? pick_core : 3'd0;
            rsp.rsp_nonce     <= pick_is_core ? core_nonce[{pick_core, 5'b0} +: 32]   : 32'd0;
            rsp.rsp_time      <= pick_is_core ? core_time[{pick_core, 5'b0} +: 32]    : 32'd0;
            rsp.rsp_version   <= pick_is_core ? core_version[{pick_core, 5'b0} +: 32] : 32'd0;
         end
         rsp.rsp_valid <= (state_reg == PRESENT) && (state_next == PRESENT) && rsp.rsp_hold_val;
      end
   end
endmodule

// File: tb/tb_core_rsp_arbiter.sv
// Testbench for core_rsp_arbiter: a response-interface model answers every
// interrupt and a scoreboard compares each served event against the queue of
// expected events pushed by the scenario tasks.
module tb_core_rsp_arbiter;
   localparam int N = 8;
   localparam logic [1:0] K_ERR = 2'd0, K_ACK = 2'd1, K_RWD = 2'd2, K_OVF = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstn;
   logic [N-1:0]    core_reward, core_ovf, core_hold;
   logic [32*N-1:0] core_nonce, core_time, core_version;
   logic            cmd_ack, cmd_err, lost_evt;

   core_rsp_arbiter_if rsp();

   core_rsp_arbiter #(.N_CORES(N), .TIMEOUT_CYCLES(16)) dut (
      .sys_clk(clk), .rstn(rstn),
      .core_reward(core_reward), .core_ovf(core_ovf),
      .core_nonce(core_nonce), .core_time(core_time), .core_version(core_version),
      .core_hold(core_hold), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
      .rsp(rsp), .lost_evt(lost_evt)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  addr;
      logic [31:0] nonce;
      logic [31:0] tme;
      logic [31:0] ver;
      bit          valid;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0;
   int          failures = 0;
   bit          model_busy = 1'b0;
   bit          model_stall = 1'b0;
   logic [31:0] nonce_tab[N], time_tab[N], ver_tab[N];

   function automatic ev_t mk(input logic [1:0] kind, input int core, input bit vld);
      ev_t e;
      e.kind  = kind;
      e.valid = vld;
      if (kind == K_ERR || kind == K_ACK) begin
         e.addr = 3'd0; e.nonce = 32'd0; e.tme = 32'd0; e.ver = 32'd0;
      end else begin
         e.addr = 3'(core); e.nonce = nonce_tab[core]; e.tme = time_tab[core]; e.ver = ver_tab[core];
      end
      return e;
   endfunction

   // Response-interface model plus scoreboard
   initial begin : model
      ev_t o, e;
      logic [3:0] irq;
      rsp.rsp_idle     = 1'b1;
      rsp.rsp_hold_val = 1'b0;
      forever begin
         @(negedge clk);
         irq = {rsp.rsp_err, rsp.rsp_ack, rsp.rsp_reward_found, rsp.rsp_nonce_overflow};
         if (irq != 4'd0) begin
            model_busy   = 1'b1;
            rsp.rsp_idle = 1'b0;
            o.kind  = rsp.rsp_err ? K_ERR : rsp.rsp_ack ? K_ACK : rsp.rsp_reward_found ? K_RWD : K_OVF;
            o.addr  = rsp.rsp_core_addr;
            o.valid = 1'b0;
            checks++;
            if ($countones(irq) != 1) begin
               failures++;
               $display("FAIL irq_onehot got=%b required exactly one bit", irq);
            end
            @(negedge clk);
            irq = {rsp.rsp_err, rsp.rsp_ack, rsp.rsp_reward_found, rsp.rsp_nonce_overflow};
            checks++;
            if (irq !== 4'd0) begin
               failures++;
               $display("FAIL irq_single_cycle got=%b required=0000", irq);
            end
            if (!model_stall) rsp.rsp_hold_val = 1'b1;
            for (int w = 0; w < 4 && !o.valid; w++) begin
               @(negedge clk);
               if (rsp.rsp_valid === 1'b1) o.valid = 1'b1;
            end
            o.nonce = rsp.rsp_nonce; o.tme = rsp.rsp_time; o.ver = rsp.rsp_version;
            if (model_stall) begin
               repeat (30) @(negedge clk);
            end else begin
               repeat (2) @(negedge clk);
               rsp.rsp_hold_val = 1'b0;
               @(negedge clk);
               checks++;
               if (rsp.rsp_valid !== 1'b0) begin
                  failures++;
                  $display("FAIL valid_drop got=%b required=0", rsp.rsp_valid);
               end
               @(negedge clk);
            end
            $display("event kind=%0d addr=%0d nonce=%h time=%h ver=%h valid=%0d",
                     o.kind, o.addr, o.nonce, o.tme, o.ver, o.valid);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_unexpected kind=%0d addr=%0d required no event", o.kind, o.addr);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (o.kind !== e.kind || o.addr !== e.addr) begin
                  failures++;
                  $display("FAIL sb_kind_addr got kind=%0d addr=%0d required kind=%0d addr=%0d",
                           o.kind, o.addr, e.kind, e.addr);
               end
               checks++;
               if (o.nonce !== e.nonce || o.tme !== e.tme || o.ver !== e.ver) begin
                  failures++;
                  $display("FAIL sb_payload got %h/%h/%h required %h/%h/%h",
                           o.nonce, o.tme, o.ver, e.nonce, e.tme, e.ver);
               end
               checks++;
               if (o.valid !== e.valid) begin
                  failures++;
                  $display("FAIL sb_valid got=%0d required=%0d", o.valid, e.valid);
               end
            end
            rsp.rsp_idle = 1'b1;
            model_stall  = 1'b0;
            model_busy   = 1'b0;
         end
      end
   end

   task automatic pulse(input logic [N-1:0] rwd, input logic [N-1:0] ovf,
                        input logic ack, input logic err);
      @(negedge clk);
      core_reward = rwd; core_ovf = ovf; cmd_ack = ack; cmd_err = err;
      @(negedge clk);
      core_reward = '0; core_ovf = '0; cmd_ack = 1'b0; cmd_err = 1'b0;
   endtask

   task automatic wait_quiet(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !model_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      core_reward = '0; core_ovf = '0; cmd_ack = 1'b0; cmd_err = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (core_hold !== '0 || lost_evt !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold_lost got hold=%b lost=%b required 0/0", core_hold, lost_evt);
      end
      checks++;
      if ({rsp.rsp_err, rsp.rsp_ack, rsp.rsp_reward_found, rsp.rsp_nonce_overflow, rsp.rsp_valid} !== 5'd0) begin
         failures++;
         $display("FAIL reset_irq_valid got nonzero interrupt/valid required 0");
      end
      checks++;
      if (rsp.rsp_core_addr !== 3'd0 || rsp.rsp_nonce !== 32'd0 || rsp.rsp_time !== 32'd0 || rsp.rsp_version !== 32'd0) begin
         failures++;
         $display("FAIL reset_payload got addr=%0d nonce=%h required 0", rsp.rsp_core_addr, rsp.rsp_nonce);
      end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit ok;
      exp_q.push_back(mk(K_RWD, 1, 1'b1));
      exp_q.push_back(mk(K_RWD, 5, 1'b1));
      exp_q.push_back(mk(K_RWD, 6, 1'b1));
      pulse(8'b0110_0010, '0, 1'b0, 1'b0);
      wait_quiet(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_pass1_timeout got pending=%0d required 0", exp_q.size()); end
      repeat (2) @(negedge clk);
      exp_q.push_back(mk(K_RWD, 1, 1'b1));
      exp_q.push_back(mk(K_RWD, 6, 1'b1));
      pulse(8'b0100_0010, '0, 1'b0, 1'b0);
      wait_quiet(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_pass2_timeout got pending=%0d required 0", exp_q.size()); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_priority();
      bit ok;
      exp_q.push_back(mk(K_ERR, 0, 1'b1));
      exp_q.push_back(mk(K_ACK, 0, 1'b1));
      exp_q.push_back(mk(K_OVF, 0, 1'b1));
      pulse('0, 8'b0000_0001, 1'b1, 1'b1);
      wait_quiet(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL prio_timeout got pending=%0d required 0", exp_q.size()); end
      checks++;
      if (lost_evt !== 1'b0) begin failures++; $display("FAIL prio_lost got=%b required=0", lost_evt); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      bit ok, seen;
      exp_q.push_back(mk(K_RWD, 3, 1'b1));
      pulse(8'b0000_1000, '0, 1'b0, 1'b0);
      checks++;
      if (core_hold[3] !== 1'b1 || rsp.rsp_reward_found !== 1'b0) begin
         failures++;
         $display("FAIL single_hold_rise got hold3=%b irq=%b required 1/0", core_hold[3], rsp.rsp_reward_found);
      end
      @(negedge clk);
      checks++;
      if (rsp.rsp_reward_found !== 1'b1 || rsp.rsp_core_addr !== 3'd3) begin
         failures++;
         $display("FAIL single_latency got irq=%b addr=%0d required 1/3", rsp.rsp_reward_found, rsp.rsp_core_addr);
      end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (rsp.rsp_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || core_hold[3] !== 1'b1) begin
         failures++;
         $display("FAIL single_hold_during_valid got valid=%b hold3=%b required 1/1", seen, core_hold[3]);
      end
      wait_quiet(100, ok);
      @(negedge clk);
      checks++;
      if (!ok || core_hold[3] !== 1'b0) begin
         failures++;
         $display("FAIL single_hold_drop got done=%b hold3=%b required 1/0", ok, core_hold[3]);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_dual();
      bit ok, held;
      exp_q.push_back(mk(K_RWD, 2, 1'b1));
      exp_q.push_back(mk(K_OVF, 2, 1'b1));
      pulse(8'b0000_0100, 8'b0000_0100, 1'b0, 1'b0);
      ok = 1'b0; held = 1'b1;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !model_busy) ok = 1'b1;
         else if (core_hold[2] !== 1'b1) held = 1'b0;
      end
      checks++;
      if (!ok || !held) begin
         failures++;
         $display("FAIL dual_hold got done=%b held=%b required 1/1", ok, held);
      end
      @(negedge clk);
      checks++;
      if (core_hold[2] !== 1'b0) begin failures++; $display("FAIL dual_hold_drop got=%b required=0", core_hold[2]); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_drop_reset();
      bit ok, seen;
      exp_q.push_back(mk(K_RWD, 4, 1'b1));
      @(negedge clk); core_reward = 8'b0001_0000;
      @(negedge clk);
      @(negedge clk); core_reward = '0;
      checks++;
      if (lost_evt !== 1'b1) begin failures++; $display("FAIL drop_lost got=%b required=1", lost_evt); end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (rsp.rsp_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL drop_present got valid=0 required=1"); end
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (core_hold !== '0 || lost_evt !== 1'b0 || rsp.rsp_valid !== 1'b0 || rsp.rsp_core_addr !== 3'd0
          || rsp.rsp_nonce !== 32'd0 || rsp.rsp_time !== 32'd0 || rsp.rsp_version !== 32'd0) begin
         failures++;
         $display("FAIL midreset_outputs got hold=%b lost=%b valid=%b addr=%0d nonce=%h required all 0",
                  core_hold, lost_evt, rsp.rsp_valid, rsp.rsp_core_addr, rsp.rsp_nonce);
      end
      rstn = 1'b1;
      wait_quiet(100, ok);
      repeat (10) @(negedge clk);
      checks++;
      if (!ok || model_busy || core_hold !== '0) begin
         failures++;
         $display("FAIL midreset_discard got done=%b busy=%b hold=%b required 1/0/0", ok, model_busy, core_hold);
      end
   endtask

`ifdef RSP_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      exp_q.push_back(mk(K_RWD, 0, 1'b0));
      exp_q.push_back(mk(K_RWD, 1, 1'b1));
      model_stall = 1'b1;
      pulse(8'b0000_0011, '0, 1'b0, 1'b0);
      wait_quiet(400, ok);
      checks++;
      if (!ok || lost_evt !== 1'b1) begin
         failures++;
         $display("FAIL timeout_abandon got done=%b lost=%b required 1/1", ok, lost_evt);
      end
   endtask
`endif

   initial begin : watchdog
      #500000;
      $display("FAIL global_watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      for (int i = 0; i < N; i++) begin
         nonce_tab[i] = 32'hA000_0000 | i;
         time_tab[i]  = 32'hB000_0000 | (i << 4);
         ver_tab[i]   = 32'hC000_0000 | (i << 8);
      end
      nonce_tab[3] = 32'hDEADBEEF;
      time_tab[3]  = 32'h11223344;
      ver_tab[3]   = 32'h20000000;
      for (int i = 0; i < N; i++) begin
         core_nonce[32*i +: 32]   = nonce_tab[i];
         core_time[32*i +: 32]    = time_tab[i];
         core_version[32*i +: 32] = ver_tab[i];
      end
      test_reset();
      test_round_robin();
      test_priority();
      test_single();
      test_dual();
      test_drop_reset();
`ifdef RSP_ARB_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
